// File: rtl/bus_cmd_master_pkg.sv
// Shared types for the bus command master: bus command/response codes, FSM states
// and a helper that maps a request direction onto a bus command.
package bus_cmd_master_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE = 2'd0,
        CMD_WR   = 2'd1,
        CMD_RD   = 2'd2
    } mcmd_e;

    typedef enum logic [1:0] {
        RESP_NULL = 2'd0,
        RESP_DVA  = 2'd1,
        RESP_ERR  = 2'd2
    } sresp_e;

    typedef enum logic [1:0] {
        M_IDLE,
        M_CMD,
        M_RESP
    } master_state_e;

    function automatic mcmd_e cmd_of(input logic wr);
        return wr ? CMD_WR : CMD_RD;
    endfunction

endpackage

// File: rtl/bus_cmd_master_if.sv
// Single-outstanding command/response bus between an initiator and a target.
interface bus_cmd_master_if
    import bus_cmd_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    mcmd_e                  MCmd;
    logic [ADDR_WIDTH-1:0]  MAddr;
    logic [DATA_WIDTH-1:0]  MData;
    logic                   MRespAccept;
    logic                   SCmdAccept;
    sresp_e                 SResp;
    logic [DATA_WIDTH-1:0]  SData;

    modport master (
        output MCmd, MAddr, MData, MRespAccept,
        input  SCmdAccept, SResp, SData
    );

    modport slave (
        input  MCmd, MAddr, MData, MRespAccept,
        output SCmdAccept, SResp, SData
    );
endinterface

// File: rtl/bus_cmd_master_fifo.sv
// Synchronous FIFO holding queued bus commands; pointers carry one extra wrap bit
// so full and empty are distinguished without a separate counter.
module bus_cmd_master_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/bus_cmd_master.sv
// Bus initiator: queues requests, issues one bus transaction at a time, returns responses.
// Optional response timeout is built when BUS_CMD_MASTER_TIMEOUT_EN is defined.
module bus_cmd_master
    import bus_cmd_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  Clk,
    input  logic                  MReset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    bus_cmd_master_if.master      bus
);
    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } cmd_entry_t;

    cmd_entry_t    push_entry;
    cmd_entry_t    head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    master_state_e state;
    master_state_e state_next;
    logic          cur_wr;
    logic          resp_seen;
    logic          timeout;
    logic          drain;
    logic          resp_done;

    assign req_ready  = MReset_n && !fifo_full;
    assign push       = req_valid && req_ready;
    assign push_entry = '{wr: req_wr, addr: req_addr, data: req_data};

    bus_cmd_master_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH ($bits(cmd_entry_t))
    ) u_fifo (
        .clk   (Clk),
        .rst_n (MReset_n),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign resp_seen = (bus.SResp != RESP_NULL);

`ifdef BUS_CMD_MASTER_TIMEOUT_EN
    localparam int TO_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TO_W    = (TO_BITS < 8) ? 8 : ((TO_BITS > 16) ? 16 : TO_BITS);

    logic [TO_W-1:0] to_cnt;

    // Counter sits at zero outside RESP, so it is cleared on every RESP entry.
    always_ff @(posedge Clk or negedge MReset_n) begin
        if (!MReset_n) begin
            to_cnt <= '0;
            drain  <= 1'b0;
        end else begin
            if (state != M_RESP) to_cnt <= '0;
            else                 to_cnt <= to_cnt + TO_W'(1);
            if (timeout)        drain <= 1'b1;
            else if (resp_seen) drain <= 1'b0;
        end
    end

    assign timeout = (state == M_RESP) && !resp_seen &&
                     (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    // Kept so the parameter list is identical in both builds.
    localparam int timeout_cycles_unused = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
    assign drain   = 1'b0;
`endif

    assign resp_done = (state == M_RESP) && (resp_seen || timeout);

    always_ff @(posedge Clk or negedge MReset_n) begin
        if (!MReset_n) state <= M_IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            M_IDLE:  if (!fifo_empty && !rsp_valid) state_next = M_CMD;
            M_CMD:   if (bus.SCmdAccept)            state_next = M_RESP;
            M_RESP:  if (resp_done)                 state_next = M_IDLE;
            default:                                state_next = M_IDLE;
        endcase
    end

    // A late response after a timeout is still acknowledged (drain) so the target can retire it.
    always_comb begin
        pop             = 1'b0;
        bus.MRespAccept = drain;
        case (state)
            M_IDLE:  pop             = !fifo_empty && !rsp_valid;
            M_RESP:  bus.MRespAccept = !rsp_valid || drain;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge MReset_n) begin
        if (!MReset_n) begin
            bus.MCmd  <= CMD_IDLE;
            bus.MAddr <= '0;
            bus.MData <= '0;
            cur_wr    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (pop) begin
                bus.MCmd  <= cmd_of(head.wr);
                bus.MAddr <= head.addr;
                bus.MData <= head.data;
                cur_wr    <= head.wr;
            end else if ((state == M_CMD) && bus.SCmdAccept) begin
                bus.MCmd  <= CMD_IDLE;
            end

            if (resp_done) begin
                rsp_valid <= 1'b1;
                rsp_err   <= timeout || (bus.SResp != RESP_DVA);
                rsp_data  <= (cur_wr || timeout) ? '0 : bus.SData;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule
